// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C EEPROM controller: FSM states, byte selectors,
// default device address and R/W bit values.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START,
    TX_BYTE,
    RX_ACK,
    RSTART,
    RX_BYTE,
    TX_NACK,
    STOP,
    DONE
  } state_t;

  // Which byte of the transfer is currently on the wire; picks the successor after each ACK.
  typedef enum logic [1:0] {
    BYTE_DEV_W,
    BYTE_WORD,
    BYTE_DATA,
    BYTE_DEV_R
  } byte_sel_t;

  localparam logic [6:0] EEPROM_DEV_ADDR = 7'h56;
  localparam logic       RW_WRITE        = 1'b0;
  localparam logic       RW_READ         = 1'b1;

  function automatic logic [7:0] addr_byte(input logic [6:0] dev, input logic rw_bit);
    return {dev, rw_bit};
  endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-bit tick divider: one-cycle tick every CLK_DIV clocks while enabled,
// counter held at zero otherwise.
module i2c_tick_gen #(
  parameter int CLK_DIV = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (!en || cnt_reg == LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign tick = en && (cnt_reg == LAST);

endmodule

// File: rtl/i2c_eeprom_ctrl.sv
// I2C master for single-byte EEPROM write and random read. Each bit is four
// ticks (ph0..ph3); SCL is push-pull, SDA open-drain.
module i2c_eeprom_ctrl
  import i2c_pkg::*;
#(
  parameter int         CLK_DIV  = 25,
  parameter logic [6:0] DEV_ADDR = EEPROM_DEV_ADDR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] word_addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       ack_err,
  output logic       scl,
  inout  wire        sda
);

  state_t    state_reg, state_next;
  byte_sel_t byte_sel_reg, byte_sel_next;
  logic [1:0] ph_reg, ph_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic [7:0] tx_sh_reg, tx_sh_next;
  logic [7:0] rx_sh_reg, rx_sh_next;
  logic [7:0] rdata_reg, rdata_next;
  logic [7:0] word_addr_reg, word_addr_next;
  logic [7:0] wdata_reg, wdata_next;
  logic       rw_reg, rw_next;
  logic       scl_reg, scl_next;
  logic       sda_low_reg, sda_low_next;
  logic       ack_err_reg, ack_err_next;
  logic       tick;

  i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (busy),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      byte_sel_reg  <= BYTE_DEV_W;
      ph_reg        <= '0;
      bit_cnt_reg   <= '0;
      tx_sh_reg     <= '0;
      rx_sh_reg     <= '0;
      rdata_reg     <= '0;
      word_addr_reg <= '0;
      wdata_reg     <= '0;
      rw_reg        <= 1'b0;
      scl_reg       <= 1'b1;
      sda_low_reg   <= 1'b0;
      ack_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      byte_sel_reg  <= byte_sel_next;
      ph_reg        <= ph_next;
      bit_cnt_reg   <= bit_cnt_next;
      tx_sh_reg     <= tx_sh_next;
      rx_sh_reg     <= rx_sh_next;
      rdata_reg     <= rdata_next;
      word_addr_reg <= word_addr_next;
      wdata_reg     <= wdata_next;
      rw_reg        <= rw_next;
      scl_reg       <= scl_next;
      sda_low_reg   <= sda_low_next;
      ack_err_reg   <= ack_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    byte_sel_next  = byte_sel_reg;
    ph_next        = ph_reg;
    bit_cnt_next   = bit_cnt_reg;
    tx_sh_next     = tx_sh_reg;
    rx_sh_next     = rx_sh_reg;
    rdata_next     = rdata_reg;
    word_addr_next = word_addr_reg;
    wdata_next     = wdata_reg;
    rw_next        = rw_reg;
    scl_next       = scl_reg;
    sda_low_next   = sda_low_reg;
    ack_err_next   = ack_err_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next     = START;
          rw_next        = rw;
          word_addr_next = word_addr;
          wdata_next     = wdata;
          ack_err_next   = 1'b0;
          byte_sel_next  = BYTE_DEV_W;
          tx_sh_next     = addr_byte(DEV_ADDR, RW_WRITE);
          ph_next        = 2'd0;
          bit_cnt_next   = 3'd0;
        end
      end
      DONE: state_next = IDLE;
      default: begin
        if (tick) begin
          ph_next = ph_reg + 2'd1;
          case (state_reg)
            START: begin
              case (ph_reg)
                2'd0: sda_low_next = 1'b1;
                2'd2: begin
                  scl_next   = 1'b0;
                  ph_next    = 2'd0;
                  state_next = TX_BYTE;
                end
                default: ;
              endcase
            end
            TX_BYTE: begin
              case (ph_reg)
                2'd0: sda_low_next = !tx_sh_reg[7];
                2'd1: scl_next = 1'b1;
                2'd3: begin
                  scl_next     = 1'b0;
                  tx_sh_next   = {tx_sh_reg[6:0], 1'b0};
                  bit_cnt_next = bit_cnt_reg + 3'd1;
                  if (bit_cnt_reg == 3'd7) state_next = RX_ACK;
                end
                default: ;
              endcase
            end
            RX_ACK: begin
              case (ph_reg)
                2'd0: sda_low_next = 1'b0;
                2'd1: scl_next = 1'b1;
                2'd2: rx_sh_next = {rx_sh_reg[6:0], sda};
                default: begin
                  scl_next = 1'b0;
                  // rx_sh[0] holds the bit just sampled: 1 means the slave NACKed.
                  if (rx_sh_reg[0]) begin
                    ack_err_next = 1'b1;
                    state_next   = STOP;
                  end else begin
                    case (byte_sel_reg)
                      BYTE_DEV_W: begin
                        byte_sel_next = BYTE_WORD;
                        tx_sh_next    = word_addr_reg;
                        state_next    = TX_BYTE;
                      end
                      BYTE_WORD: begin
                        if (rw_reg == RW_READ) begin
                          state_next = RSTART;
                        end else begin
                          byte_sel_next = BYTE_DATA;
                          tx_sh_next    = wdata_reg;
                          state_next    = TX_BYTE;
                        end
                      end
                      BYTE_DATA:  state_next = STOP;
                      BYTE_DEV_R: state_next = RX_BYTE;
                      default:    state_next = STOP;
                    endcase
                  end
                end
              endcase
            end
            RSTART: begin
              case (ph_reg)
                2'd0: sda_low_next = 1'b0;
                2'd1: scl_next = 1'b1;
                2'd2: sda_low_next = 1'b1;
                default: begin
                  scl_next      = 1'b0;
                  byte_sel_next = BYTE_DEV_R;
                  tx_sh_next    = addr_byte(DEV_ADDR, RW_READ);
                  state_next    = TX_BYTE;
                end
              endcase
            end
            RX_BYTE: begin
              case (ph_reg)
                2'd0: sda_low_next = 1'b0;
                2'd1: scl_next = 1'b1;
                2'd2: rx_sh_next = {rx_sh_reg[6:0], sda};
                default: begin
                  scl_next     = 1'b0;
                  bit_cnt_next = bit_cnt_reg + 3'd1;
                  if (bit_cnt_reg == 3'd7) state_next = TX_NACK;
                end
              endcase
            end
            TX_NACK: begin
              case (ph_reg)
                2'd0: sda_low_next = 1'b0;
                2'd1: scl_next = 1'b1;
                2'd3: begin
                  scl_next   = 1'b0;
                  rdata_next = rx_sh_reg;
                  state_next = STOP;
                end
                default: ;
              endcase
            end
            STOP: begin
              case (ph_reg)
                2'd0: sda_low_next = 1'b1;
                2'd1: scl_next = 1'b1;
                2'd2: sda_low_next = 1'b0;
                default: state_next = DONE;
              endcase
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  assign busy    = (state_reg != IDLE) && (state_reg != DONE);
  assign done    = (state_reg == DONE);
  assign rdata   = rdata_reg;
  assign ack_err = ack_err_reg;
  assign scl     = scl_reg;
  assign sda     = sda_low_reg ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_eeprom_ctrl.sv
// Bench for i2c_eeprom_ctrl: behavioural EEPROM slave plus bus decoder that
// records START/STOP events and byte frames, checked against directed vectors.
module tb_i2c_eeprom_ctrl;

  localparam int CLK_DIV = 4;
  localparam logic [11:0] EV_S = 12'h800;
  localparam logic [11:0] EV_P = 12'h900;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [7:0] word_addr = 8'h00;
  logic [7:0] wdata = 8'h00;
  logic       busy, done, ack_err, scl;
  logic [7:0] rdata;
  wire        sda;
  logic       slave_low = 1'b0;

  pullup (sda);
  assign sda = slave_low ? 1'b0 : 1'bz;

  i2c_eeprom_ctrl #(.CLK_DIV(CLK_DIV), .DEV_ADDR(7'h56)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rw        (rw),
    .word_addr (word_addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .rdata     (rdata),
    .ack_err   (ack_err),
    .scl       (scl),
    .sda       (sda)
  );

  initial forever #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- slave model and bus decoder ----------------
  logic [11:0] tr[$];
  logic [7:0]  mem [256] = '{default: 8'h00};
  logic [6:0]  slave_addr = 7'h56;
  int          txn_base = 0;
  int          done_cnt = 0;
  int          cyc = 0;
  int          s_cyc = 0, rise_cyc = 0, rise_prev = 0;
  int          s_hold = -1, p_delay = -1, bit_period = -1;
  bit          s_pend = 1'b0;

  initial begin
    logic scl_q, sda_q;
    logic [7:0] sh, ptr, txb;
    int bitn, fstate, nxt;
    scl_q = 1'b1; sda_q = 1'b1; sh = 0; ptr = 0; txb = 0;
    bitn = 0; fstate = 0; nxt = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (done) done_cnt++;
      if (scl_q && scl && sda_q && !sda) begin
        if (tr.size() == txn_base) begin
          s_cyc = cyc; s_pend = 1'b1; s_hold = -1; bit_period = -1;
        end
        tr.push_back(EV_S);
        bitn = 0; fstate = 1; slave_low = 1'b0;
      end else if (scl_q && scl && !sda_q && sda) begin
        tr.push_back(EV_P);
        p_delay = cyc - rise_cyc;
        fstate = 0; slave_low = 1'b0;
      end else if (!scl_q && scl) begin
        rise_prev = rise_cyc;
        rise_cyc  = cyc;
        if (fstate != 0) begin
          if (bitn < 8) begin
            sh = {sh[6:0], sda};
            bitn++;
            if (bitn == 2 && bit_period < 0) bit_period = rise_cyc - rise_prev;
          end else begin
            tr.push_back({3'b000, sh, sda});
            bitn = 9;
          end
        end
      end else if (scl_q && !scl) begin
        if (s_pend) begin
          s_hold = cyc - s_cyc; s_pend = 1'b0;
        end
        if (fstate != 0) begin
          if (bitn == 8) begin
            slave_low = 1'b0;
            case (fstate)
              1: if (sh[7:1] == slave_addr) begin
                   slave_low = 1'b1; nxt = sh[0] ? 4 : 2;
                 end else nxt = 0;
              2: begin ptr = sh; slave_low = 1'b1; nxt = 3; end
              3: begin mem[ptr] = sh; slave_low = 1'b1; nxt = 0; end
              default: nxt = 0;
            endcase
          end else if (bitn == 9) begin
            bitn = 0; fstate = nxt; slave_low = 1'b0;
            if (nxt == 4) begin
              txb = mem[ptr]; slave_low = !txb[7];
            end
          end else if (fstate == 4 && bitn >= 1 && bitn <= 7) begin
            slave_low = !txb[7 - bitn];
          end
        end
      end
      scl_q = scl;
      sda_q = sda;
    end
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic             rw;
    logic [7:0]       addr;
    logic [7:0]       wdata;
    logic [6:0]       slave;
    bit               extra;
    logic             exp_err;
    logic [7:0]       exp_rdata;
    logic [7:0]       exp_mem;
    int               exp_len;
    logic [7:0][11:0] exp_tr;
  } vec_t;

  function automatic logic [7:0][11:0] seq(input logic [11:0] e0, e1, e2,
                                           input logic [11:0] e3 = 0, e4 = 0, e5 = 0, e6 = 0);
    logic [7:0][11:0] s;
    s = '0;
    s[0] = e0; s[1] = e1; s[2] = e2; s[3] = e3; s[4] = e4; s[5] = e5; s[6] = e6;
    return s;
  endfunction

  task automatic run_txn(input logic r, input logic [7:0] a, input logic [7:0] d, input bit extra,
                         output logic got_err, output logic [7:0] got_rdata, output bit ok);
    got_err = 1'b0; got_rdata = 8'h00; ok = 1'b0;
    txn_base = tr.size();
    @(negedge clk);
    start = 1'b1; rw = r; word_addr = a; wdata = d;
    @(negedge clk);
    start = 1'b0;
    check("busy after start", busy, 1);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (extra && i == 60) begin
        start = 1'b1; rw = ~r; word_addr = 8'hFF; wdata = 8'h00;
      end else if (extra && i == 61) begin
        start = 1'b0;
      end
      if (done) begin
        ok = 1'b1; got_err = ack_err; got_rdata = rdata;
        check("busy low with done", busy, 0);
        if (extra) start = 1'b1;
        break;
      end
    end
    @(negedge clk);
    start = 1'b0;
    check("done reached", ok, 1);
    if (extra) check("start at done ignored", busy, 0);
  endtask

  task automatic do_vec(input vec_t vv, input string tag);
    logic e;
    logic [7:0] rd;
    bit ok;
    int d0;
    slave_addr = vv.slave;
    d0 = done_cnt;
    run_txn(vv.rw, vv.addr, vv.wdata, vv.extra, e, rd, ok);
    repeat (10) @(negedge clk);
    $display("txn %s rw=%0d addr=%h wdata=%h slave=%h ack_err=%0d rdata=%h frames=%0d",
             tag, vv.rw, vv.addr, vv.wdata, vv.slave, e, rd, tr.size() - txn_base);
    check($sformatf("%s ack_err", tag), e, vv.exp_err);
    check($sformatf("%s rdata", tag), rd, vv.exp_rdata);
    check($sformatf("%s done count", tag), done_cnt - d0, 1);
    check($sformatf("%s scl idle", tag), scl, 1);
    check($sformatf("%s sda idle", tag), sda, 1);
    check($sformatf("%s mem", tag), mem[vv.addr], vv.exp_mem);
    check($sformatf("%s start hold", tag), s_hold, 2 * CLK_DIV);
    check($sformatf("%s bit period", tag), bit_period, 4 * CLK_DIV);
    check($sformatf("%s stop delay", tag), p_delay, CLK_DIV);
    check($sformatf("%s event count", tag), tr.size() - txn_base, vv.exp_len);
    for (int i = 0; i < vv.exp_len; i++) begin
      if (txn_base + i < tr.size())
        check($sformatf("%s event %0d", tag, i), tr[txn_base + i], vv.exp_tr[i]);
    end
  endtask

  vec_t vecs[8];

  initial begin
    bit seen;
    int d0;
    vecs[0] = '{rw:1'b0, addr:8'h10, wdata:8'hA5, slave:7'h56, extra:1'b0, exp_err:1'b0,
                exp_rdata:8'h00, exp_mem:8'hA5, exp_len:5,
                exp_tr:seq(EV_S, 12'h158, 12'h020, 12'h14A, EV_P)};
    vecs[1] = '{rw:1'b1, addr:8'h10, wdata:8'h00, slave:7'h56, extra:1'b0, exp_err:1'b0,
                exp_rdata:8'hA5, exp_mem:8'hA5, exp_len:7,
                exp_tr:seq(EV_S, 12'h158, 12'h020, EV_S, 12'h15A, 12'h14B, EV_P)};
    vecs[2] = '{rw:1'b0, addr:8'h3C, wdata:8'h5A, slave:7'h56, extra:1'b1, exp_err:1'b0,
                exp_rdata:8'hA5, exp_mem:8'h5A, exp_len:5,
                exp_tr:seq(EV_S, 12'h158, 12'h078, 12'h0B4, EV_P)};
    vecs[3] = '{rw:1'b1, addr:8'h3C, wdata:8'h00, slave:7'h56, extra:1'b1, exp_err:1'b0,
                exp_rdata:8'h5A, exp_mem:8'h5A, exp_len:7,
                exp_tr:seq(EV_S, 12'h158, 12'h078, EV_S, 12'h15A, 12'h0B5, EV_P)};
    vecs[4] = '{rw:1'b1, addr:8'h10, wdata:8'h00, slave:7'h57, extra:1'b0, exp_err:1'b1,
                exp_rdata:8'h5A, exp_mem:8'hA5, exp_len:3,
                exp_tr:seq(EV_S, 12'h159, EV_P)};
    vecs[5] = '{rw:1'b0, addr:8'h20, wdata:8'hFF, slave:7'h57, extra:1'b0, exp_err:1'b1,
                exp_rdata:8'h5A, exp_mem:8'h00, exp_len:3,
                exp_tr:seq(EV_S, 12'h159, EV_P)};
    vecs[6] = '{rw:1'b0, addr:8'hFF, wdata:8'h3C, slave:7'h56, extra:1'b0, exp_err:1'b0,
                exp_rdata:8'h5A, exp_mem:8'h3C, exp_len:5,
                exp_tr:seq(EV_S, 12'h158, 12'h1FE, 12'h078, EV_P)};
    vecs[7] = '{rw:1'b1, addr:8'hFF, wdata:8'h00, slave:7'h56, extra:1'b0, exp_err:1'b0,
                exp_rdata:8'h3C, exp_mem:8'h3C, exp_len:7,
                exp_tr:seq(EV_S, 12'h158, 12'h1FE, EV_S, 12'h15A, 12'h079, EV_P)};

    // Reset state
    @(negedge clk);
    check("reset scl", scl, 1);
    check("reset sda", sda, 1);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset ack_err", ack_err, 0);
    check("reset rdata", rdata, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int v = 0; v < 8; v++) do_vec(vecs[v], $sformatf("vec%0d", v));

    // Reset in the middle of the word-address byte
    slave_addr = 7'h56;
    d0 = done_cnt;
    txn_base = tr.size();
    @(negedge clk);
    start = 1'b1; rw = 1'b0; word_addr = 8'h44; wdata = 8'h99;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (tr.size() >= txn_base + 2) begin seen = 1'b1; break; end
    end
    check("abort first frame seen", seen, 1);
    repeat (40) @(negedge clk);
    check("abort busy before rst", busy, 1);
    rst = 1'b1;
    #1;
    check("abort scl", scl, 1);
    check("abort sda", sda, 1);
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort rdata", rdata, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("abort no done", done_cnt - d0, 0);
    check("abort mem untouched", mem[8'h44], 8'h00);
    $display("txn abort rw=0 addr=44 reset during word byte");

    do_vec(vecs[1], "after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/i2c_eeprom_ctrl.md
I2C_EEPROM_CTRL -- requirements
Module: i2c_eeprom_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 25: clk cycles per SCL quarter-period; legal range >= 2.
REQ-002 Parameter DEV_ADDR, default 7'h56: 7-bit EEPROM device address.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  one-cycle transaction request; sampled only in IDLE.
REQ-006 rw  input  1  1 = random read, 0 = byte write; captured with start.
REQ-007 word_addr  input  8  EEPROM word address; captured with start.
REQ-008 wdata  input  8  write byte; captured with start.
REQ-009 busy  output  1  high from the cycle after an accepted start until done.
REQ-010 done  output  1  one-cycle pulse at transaction end (success or error).
REQ-011 rdata  output  8  last byte read; updated only on a successful read.
REQ-012 ack_err  output  1  valid with done; 1 = slave NACKed any address or data byte.
REQ-013 scl  output  1  I2C clock, push-pull; idle high.
REQ-014 sda  inout  1  I2C data, open-drain: drives 0 or Z, never 1.

Function
REQ-015 Free-running tick counter: one-cycle tick every CLK_DIV clk cycles while busy; reset to 0 in IDLE.
REQ-016 Each bit takes 4 ticks: ph0 SCL low, SDA updated; ph1 SCL rises; ph2 SCL high, SDA sampled; ph3 SCL falls.
REQ-017 States: IDLE, START, TX_BYTE, RX_ACK, RSTART, RX_BYTE, TX_NACK, STOP, DONE.
REQ-018 START: with SCL high, SDA falls; after 2 ticks SCL falls.
REQ-019 TX_BYTE: shifts out 8 bits MSB first; SDA changes only while SCL is low.
REQ-020 RX_ACK: release SDA for 1 bit; sampled 0 = ACK, 1 = NACK.
REQ-021 Write sequence: START, {DEV_ADDR,0}, ACK, word_addr, ACK, wdata, ACK, STOP, DONE.
REQ-022 Read sequence: START, {DEV_ADDR,0}, ACK, word_addr, ACK, RSTART, {DEV_ADDR,1}, ACK, RX_BYTE, TX_NACK, STOP, DONE.
REQ-023 RSTART: release SDA with SCL low; raise SCL; pull SDA low with SCL high; lower SCL.
REQ-024 RX_BYTE: SDA released; 8 bits sampled at ph2, MSB first, into a shift register.
REQ-025 TX_NACK: master leaves SDA released (1) for the 9th bit.
REQ-026 STOP: SDA low with SCL low; SCL rises; after 1 tick SDA released (rises with SCL high).
REQ-027 Any NACK in RX_ACK -> STOP immediately, skipping remaining bytes; ack_err=1 with done; rdata unchanged.
REQ-028 DONE: done=1 for one clk; busy=0 in the same cycle; next state IDLE.
REQ-029 start while busy is ignored; start in the same cycle as done is ignored.
REQ-030 Bit counter is 3 bits; wraps 7->0 at the byte boundary, which selects the next state.
REQ-031 SDA is never changed while SCL is high, except in START, RSTART and STOP.

Reset
REQ-032 On rst: state=IDLE, scl=1, sda=Z, busy=0, done=0, ack_err=0, rdata=8'h00, counters=0.
REQ-033 A reset mid-transaction aborts immediately without generating STOP; the bus is released to idle levels.

Structure
REQ-034 Shared package i2c_pkg: state enum, 7'h56 device address constant, R/W bit constants.
REQ-035 One sub-module, i2c_tick_gen (CLK_DIV divider with enable), generates the ticks; the FSM and shift registers stay in the top.

Verification (bench EEPROM slave model at 7'h56, CLK_DIV=4)
REQ-036 Write rw=0, word_addr=8'h10, wdata=8'hA5 -> SDA bytes 8'hAC, 8'h10, 8'hA5, then STOP; done=1, ack_err=0; slave mem[8'h10]=8'hA5.
REQ-037 Read rw=1, word_addr=8'h10 after REQ-036 -> bytes 8'hAC, 8'h10, RSTART, 8'hAD; rdata=8'hA5; master NACK bit = 1; done=1, ack_err=0.
REQ-038 Slave at 7'h57 (address mismatch) -> NACK after the first byte, STOP follows immediately, ack_err=1, rdata unchanged.
REQ-039 start pulsed again while busy -> ignored; exactly one done per accepted start.
REQ-040 rst asserted during the word_addr byte -> next cycle scl=1, sda=Z, busy=0; a following read completes normally.
REQ-041 Protocol monitor on every test: no SDA edge while SCL is high outside START, RSTART and STOP; SDA is never driven to 1.
